// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   - state_t   : scanner FSM states (SCAN, DEBOUNCE, HOLD)
//   - COL_IDLE  : column value with no key pressed (columns are active-low)
//   - KEY_TABLE : key code indexed by {row, col}
//   - col_decode: returns {valid, col index}; valid only if exactly one column is low
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Entry {row, col}. Listed from index 15 down to 0:
    // r3: E 0 F D, r2: 7 8 9 C, r1: 4 5 6 B, r0: 1 2 3 A
    localparam logic [15:0][3:0] KEY_TABLE = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Idle and multi-key (ghost) patterns both decode as not valid.
    function automatic logic [2:0] col_decode(input logic [3:0] c);
        case (c)
            4'b1110: col_decode = {1'b1, 2'd0};
            4'b1101: col_decode = {1'b1, 2'd1};
            4'b1011: col_decode = {1'b1, 2'd2};
            4'b0111: col_decode = {1'b1, 2'd3};
            default: col_decode = {1'b0, 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: free-running divider producing a single-cycle scan tick.
//   clk, rst_n : clock, async active-low reset
//   o_tick     : high for the one cycle where the count equals SCAN_DIV-1
module keypad_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce.
//   clk, rst_n  : 50 MHz clock, async active-low reset
//   i_col       : active-low columns (asynchronous, synchronised internally)
//   o_row       : active-low row drive, exactly one bit low
//   o_key_num   : code of the last accepted key (0-F)
//   o_key_valid : one-clock pulse when o_key_num is updated
//   o_key_hold  : high while the accepted key stays pressed
// Optional macro KEYPAD_REPEAT_EN: auto-repeat pulses on o_key_valid while
// a key is held (REPEAT_DLY ticks to first repeat, REPEAT_RATE between).
module keypad_scan #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEB_CNT     = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_col,
    output logic [3:0] o_row,
    output logic [3:0] o_key_num,
    output logic       o_key_valid,
    output logic       o_key_hold
);

    import keypad_pkg::*;

    localparam logic [3:0] DEB_LAST = 4'(DEB_CNT);

    logic       w_tick;
    logic [3:0] r_col_m, r_col_s;
    state_t     r_state;
    logic [3:0] r_row;
    logic [1:0] r_ridx;
    logic [3:0] r_col_lat;
    logic [3:0] r_deb;          // press count in DEBOUNCE, release count in HOLD
    logic [3:0] r_key_num;
    logic       r_key_valid;
    logic       r_key_hold;

    logic [2:0] w_dec;
    logic       w_valid;
    logic [1:0] w_cidx;
    logic       w_match;
    logic [3:0] w_deb_next;
    logic       w_accept;

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .o_tick(w_tick)
    );

    assign w_dec      = col_decode(r_col_s);
    assign w_valid    = w_dec[2];
    assign w_cidx     = w_dec[1:0];
    assign w_match    = (r_col_s == r_col_lat);
    // The SCAN tick that first sees the key already counts as one stable sample.
    assign w_deb_next = (r_state == SCAN) ? 4'd1 : r_deb + 4'd1;
    assign w_accept   = w_tick && w_valid && (w_deb_next == DEB_LAST) &&
                        ((r_state == SCAN) || ((r_state == DEBOUNCE) && w_match));

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DLY);
    localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_DLY + REPEAT_RATE);
    logic [15:0] r_rep;
    logic [15:0] w_rep_next;
    assign w_rep_next = r_rep + 16'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_m     <= COL_IDLE;
            r_col_s     <= COL_IDLE;
            r_state     <= SCAN;
            r_row       <= 4'b1110;
            r_ridx      <= 2'd0;
            r_col_lat   <= COL_IDLE;
            r_deb       <= 4'd0;
            r_key_num   <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_hold  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= 16'd0;
`endif
        end else begin
            r_col_m     <= i_col;
            r_col_s     <= r_col_m;
            r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            if (r_state != HOLD)
                r_rep <= 16'd0;
`endif
            if (w_accept) begin
                r_key_num   <= KEY_TABLE[{r_ridx, w_cidx}];
                r_key_valid <= 1'b1;
                r_key_hold  <= 1'b1;
                r_col_lat   <= r_col_s;
                r_deb       <= 4'd0;
                r_state     <= HOLD;
            end else if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_valid) begin
                            // Freeze the row on this key while it debounces.
                            r_col_lat <= r_col_s;
                            r_deb     <= 4'd1;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row  <= {r_row[2:0], r_row[3]};
                            r_ridx <= r_ridx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_match) begin
                            r_deb <= w_deb_next;
                        end else begin
                            r_deb   <= 4'd0;
                            r_row   <= {r_row[2:0], r_row[3]};
                            r_ridx  <= r_ridx + 2'd1;
                            r_state <= SCAN;
                        end
                    end
                    HOLD: begin
                        // Any other column (including a second key) counts as release.
                        if (w_match) begin
                            r_deb <= 4'd0;
                        end else if (r_deb + 4'd1 == DEB_LAST) begin
                            r_deb      <= 4'd0;
                            r_key_hold <= 1'b0;
                            r_row      <= {r_row[2:0], r_row[3]};
                            r_ridx     <= r_ridx + 2'd1;
                            r_state    <= SCAN;
                        end else begin
                            r_deb <= r_deb + 4'd1;
                        end
`ifdef KEYPAD_REPEAT_EN
                        // After the first repeat the counter folds back to
                        // RPT_FIRST so every later repeat is RATE ticks apart.
                        if (w_rep_next == RPT_NEXT) begin
                            r_key_valid <= 1'b1;
                            r_rep       <= RPT_FIRST;
                        end else begin
                            if (w_rep_next == RPT_FIRST)
                                r_key_valid <= 1'b1;
                            r_rep <= w_rep_next;
                        end
`endif
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign o_row       = r_row;
    assign o_key_num   = r_key_num;
    assign o_key_valid = r_key_valid;
    assign o_key_hold  = r_key_hold;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4, DEB_CNT=3.
// A keypad model pulls a column low while its pressed row is driven.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_col;
    logic [3:0] o_row;
    logic [3:0] o_key_num;
    logic       o_key_valid;
    logic       o_key_hold;

    logic [3:0] press [4];   // per row: mask of pressed columns
    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int consec  = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV(4),
        .DEB_CNT(3)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DLY(5),
        .REPEAT_RATE(2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_col      (i_col),
        .o_row      (o_row),
        .o_key_num  (o_key_num),
        .o_key_valid(o_key_valid),
        .o_key_hold (o_key_hold)
    );

    always_comb begin
        i_col = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (!o_row[r]) i_col = i_col & ~press[r];
    end

    typedef struct {
        bit         rst;
        int         r;
        logic [3:0] m;
        int         ticks;
        int         ep;
        logic [3:0] en;
        logic       eh;
        logic [3:0] er;
        string      name;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n scan ticks (4 clk each), sampling o_key_valid on every negedge.
    task automatic step(input int n);
        for (int i = 0; i < n * 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_key_valid) begin
                pulses++;
                if (prev_valid) consec++;
            end
            prev_valid = o_key_valid;
        end
    endtask

    task automatic clr_press();
        for (int r = 0; r < 4; r++) press[r] = 4'h0;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_row",   o_row,       4'b1110);
            chk("rst_num",   o_key_num,   4'h0);
            chk("rst_valid", o_key_valid, 1'b0);
            chk("rst_hold",  o_key_hold,  1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] obs;
        logic [11:0] exp_rep;

        clr_press();

        //        rst   r  mask   tk  p  num   hold  row       name
        tv[0] = '{1'b1, 0, 4'h0,  1,  0, 4'h0, 1'b0, 4'b1101, "idle_r1"};
        tv[1] = '{1'b0, 0, 4'h0,  1,  0, 4'h0, 1'b0, 4'b1011, "idle_r2"};
        tv[2] = '{1'b0, 0, 4'h0,  1,  0, 4'h0, 1'b0, 4'b0111, "idle_r3"};
        tv[3] = '{1'b0, 0, 4'h0,  1,  0, 4'h0, 1'b0, 4'b1110, "idle_r0"};
        tv[4] = '{1'b1, 2, 4'h2, 10,  1, 4'h8, 1'b1, 4'b1011, "key8_hold"};
        tv[5] = '{1'b0, 0, 4'h0,  2,  0, 4'h8, 1'b1, 4'b1011, "key8_relpart"};
        tv[6] = '{1'b0, 0, 4'h0,  1,  0, 4'h8, 1'b0, 4'b0111, "key8_reldone"};
        tv[7] = '{1'b0, 0, 4'h0,  1,  0, 4'h8, 1'b0, 4'b1110, "key8_resume"};
        tv[8] = '{1'b1, 3, 4'h5,  8,  0, 4'h0, 1'b0, 4'b1110, "ghost"};

        do_reset(1'b1);

        for (int i = 0; i < 9; i++) begin
            if (tv[i].rst) do_reset(1'b0);
            clr_press();
            press[tv[i].r] = tv[i].m;
            pulses = 0;
            step(tv[i].ticks);
            chk({tv[i].name, "_pulses"}, pulses,     tv[i].ep);
            chk({tv[i].name, "_num"},    o_key_num,  tv[i].en);
            chk({tv[i].name, "_hold"},   o_key_hold, tv[i].eh);
            chk({tv[i].name, "_row"},    o_row,      tv[i].er);
        end

        // Bounce on key A (row0/col3): 2 ticks low, 1 high, then steady.
        do_reset(1'b0);
        clr_press();
        pulses = 0;
        press[0] = 4'b1000;
        step(2);
        chk("bounce_early_pulses", pulses, 0);
        press[0] = 4'h0;
        step(1);
        chk("bounce_gap_pulses", pulses, 0);
        chk("bounce_gap_row", o_row, 4'b1101);
        press[0] = 4'b1000;
        step(5);
        chk("bounce_wait_pulses", pulses, 0);
        chk("bounce_wait_row", o_row, 4'b1110);
        step(1);
        chk("bounce_acc_pulses", pulses, 1);
        chk("bounce_acc_num", o_key_num, 4'hA);
        chk("bounce_acc_hold", o_key_hold, 1'b1);

        // Reset while holding key 5, key stays pressed through reset.
        do_reset(1'b0);
        clr_press();
        press[1] = 4'b0010;
        pulses = 0;
        step(4);
        chk("k5_pulses", pulses, 1);
        chk("k5_num", o_key_num, 4'h5);
        chk("k5_hold", o_key_hold, 1'b1);
        step(2);
        do_reset(1'b1);
        pulses = 0;
        step(3);
        chk("k5_rearm_pulses", pulses, 0);
        chk("k5_rearm_row", o_row, 4'b1101);
        step(1);
        chk("k5_reacc_pulses", pulses, 1);
        chk("k5_reacc_num", o_key_num, 4'h5);

        // Key 0 held 12 ticks past acceptance; repeats only with the macro.
        do_reset(1'b0);
        clr_press();
        press[3] = 4'b0010;
        pulses = 0;
        step(6);
        chk("k0_acc_pulses", pulses, 1);
        chk("k0_acc_hold", o_key_hold, 1'b1);
        obs = '0;
        for (int k = 0; k < 12; k++) begin
            pulses = 0;
            step(1);
            obs[k] = (pulses != 0);
        end
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 12'b0101_0101_0000;
`else
        exp_rep = 12'b0000_0000_0000;
`endif
        chk("k0_repeat_pattern", obs, exp_rep);
        chk("k0_num", o_key_num, 4'h0);
        clr_press();
        step(3);
        chk("k0_release_hold", o_key_hold, 1'b0);

        chk("no_consec_valid", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
